// File: rtl/if_prefetch_queue_if.sv
// rtl/if_prefetch_queue_if.sv - bus bundle between prefetch queue, instruction memory, EXE redirect and IF/ID
//
// Purpose: groups the redirect, IM and pipeline-output handshake signals of the
//          instruction prefetch queue.
// Modports:
//   master - the prefetch queue: drives im_req/im_addr and out_valid/out_instr/out_pc,
//            samples redirect_valid/redirect_pc, im_rdata and out_ready.
//   slave  - the environment (IM, EXE, IF/ID): the mirror image of master.
interface if_prefetch_queue_if #(
  parameter int IM_AW = 14
);
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             im_req;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_ready;

  modport master (
    input  redirect_valid, redirect_pc, im_rdata, out_ready,
    output im_req, im_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, im_rdata, out_ready,
    input  im_req, im_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch queue between IM and the IF/ID stage
//
// Purpose: owns the fetch PC, issues one word read per cycle to IM under a credit
//          rule, buffers {instr, pc} in a DEPTH-entry FIFO and presents the head
//          with a valid/ready handshake. An EXE redirect flushes everything.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous reset, active low
//   bus  - if_prefetch_queue_if.master: redirect_valid/redirect_pc (EXE),
//          im_req/im_addr/im_rdata (IM, data one cycle after req),
//          out_valid/out_instr/out_pc/out_ready (IF/ID)
// Configuration macro: PREFETCH_BYPASS_EN - when defined, a response arriving at an
//          empty FIFO is shown on out_* the same cycle and skips the FIFO if taken.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IM_AW    = 14
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          run_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [31:0]   hold_instr_q;
  logic [31:0]   hold_pc_q;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          issue;
  logic          resp;
  logic          fifo_empty;
  logic          handshake;
  logic          fifo_push;
  logic          fifo_pop;
  logic          out_valid_c;
  logic [31:0]   out_instr_c;
  logic [31:0]   out_pc_c;
  logic [CW-1:0] occupancy;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // Credit rule: entries held plus the one possibly in flight never exceed DEPTH,
  // so a response always has a slot waiting for it.
  assign occupancy  = count_q + CW'(inflight_q);
  assign fifo_empty = (count_q == '0);
  // run_q holds off the first request until the cycle after reset is released.
  assign issue      = run_q && !bus.redirect_valid && (occupancy < DEPTH_C);
  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign resp       = inflight_q && !bus.redirect_valid;

  // When empty, out_* show whatever was displayed last cycle (hold registers).
  always_comb begin
    out_valid_c = !fifo_empty;
    out_instr_c = fifo_empty ? hold_instr_q : instr_mem_q[rd_ptr_q];
    out_pc_c    = fifo_empty ? hold_pc_q    : pc_mem_q[rd_ptr_q];
`ifdef PREFETCH_BYPASS_EN
    if (resp && fifo_empty) begin
      out_valid_c = 1'b1;
      out_instr_c = bus.im_rdata;
      out_pc_c    = req_pc_q;
    end
`endif
  end

  assign handshake = out_valid_c && bus.out_ready && !bus.redirect_valid;
  assign fifo_pop  = handshake && !fifo_empty;
`ifdef PREFETCH_BYPASS_EN
  // With an empty FIFO the only thing that can be handshaken is the bypassed response.
  assign fifo_push = resp && !(fifo_empty && handshake);
`else
  assign fifo_push = resp;
`endif

  assign bus.im_req    = issue;
  assign bus.im_addr   = fetch_pc_q[IM_AW+1:2];
  assign bus.out_valid = out_valid_c;
  assign bus.out_instr = out_instr_c;
  assign bus.out_pc    = out_pc_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q        <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      inflight_q   <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
    end else begin
      run_q        <= 1'b1;
      hold_instr_q <= out_instr_c;
      hold_pc_q    <= out_pc_c;
      inflight_q   <= issue;
      if (issue) begin
        req_pc_q   <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      if (bus.redirect_valid) begin
        fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (fifo_push && !fifo_pop) begin
          assert (count_q != DEPTH_C);
        end
        if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(fifo_push) - CW'(fifo_pop);
      end
    end
  end

  // Storage needs no reset: count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rst && fifo_push) begin
      instr_mem_q[wr_ptr_q] <= bus.im_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - randomized, model-checked bench for if_prefetch_queue
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          IM_AW    = 14;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.IM_AW(IM_AW)) bus ();

  if_prefetch_queue #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .IM_AW(IM_AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: word address a holds a*4 + 0x13.
  function automatic logic [31:0] im_word(input logic [IM_AW-1:0] a);
    return {{(30-IM_AW){1'b0}}, a, 2'b00} + 32'h13;
  endfunction

  // IM: answer a request seen in cycle n during cycle n+1.
  initial begin
    logic r;
    logic [IM_AW-1:0] a;
    bus.im_rdata = 32'h0;
    forever begin
      @(negedge clk);
      r = bus.im_req;
      a = bus.im_addr;
      @(posedge clk);
      #1;
      bus.im_rdata = r ? im_word(a) : $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          model_live = 1'b0;
  bit          m_run;
  bit          m_inflight;
  logic [31:0] m_fetch, m_req_pc, m_hold_pc, m_hold_instr;
  bit          e_req, e_valid, e_resp, e_byp;
  logic [IM_AW-1:0] e_addr;
  logic [31:0] e_pc, e_instr;

  function automatic void calc();
    e_resp = m_inflight && !bus.redirect_valid;
    e_req  = m_run && !bus.redirect_valid && ((mq.size() + int'(m_inflight)) < DEPTH);
    e_addr = m_fetch[IM_AW+1:2];
    if (mq.size() > 0) begin
      e_valid = 1'b1;
      e_pc    = mq[0].pc;
      e_instr = mq[0].instr;
    end else begin
      e_valid = 1'b0;
      e_pc    = m_hold_pc;
      e_instr = m_hold_instr;
    end
    e_byp = BYP && e_resp && (mq.size() == 0);
    if (e_byp) begin
      e_valid = 1'b1;
      e_pc    = m_req_pc;
      e_instr = im_word(m_req_pc[IM_AW+1:2]);
    end
  endfunction

  always @(posedge clk) begin
    bit pop;
    calc();
    if (!rst) begin
      model_live   = 1'b1;
      m_run        = 1'b0;
      m_inflight   = 1'b0;
      m_fetch      = RESET_PC;
      m_req_pc     = RESET_PC;
      m_hold_pc    = 32'h0;
      m_hold_instr = 32'h0;
      mq.delete();
    end else if (model_live) begin
      m_hold_pc    = e_pc;
      m_hold_instr = e_instr;
      m_run        = 1'b1;
      if (bus.redirect_valid) begin
        mq.delete();
        m_fetch    = bus.redirect_pc & 32'hFFFF_FFFC;
        m_inflight = 1'b0;
      end else begin
        pop = e_valid && bus.out_ready;
        if (!(e_byp && pop)) begin
          if (pop) void'(mq.pop_front());
          if (e_resp) mq.push_back('{pc: m_req_pc, instr: im_word(m_req_pc[IM_AW+1:2])});
        end
        if (e_req) begin
          m_req_pc = m_fetch;
          m_fetch  = m_fetch + 32'd4;
        end
        m_inflight = e_req;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      calc();
      check("im_req",    bus.im_req,    e_req);
      check("im_addr",   bus.im_addr,   e_addr);
      check("out_valid", bus.out_valid, e_valid);
      check("out_pc",    bus.out_pc,    e_pc);
      check("out_instr", bus.out_instr, e_instr);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input bit ready);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready = ready;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.out_valid) break;
      tick();
      settle();
    end
  endtask

  initial begin
    int nreq, nacc, nexp;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b1;

    // 1: reset
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("rst_im_req", bus.im_req, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
    end
    rst = 1'b1; settle();
    check("rise_im_req", bus.im_req, 1'b0);
    tick(); settle();
    check("first_req", bus.im_req, 1'b1);
    check("first_addr", bus.im_addr, 14'd0);
    tick(); settle();
    check("addr1", bus.im_addr, 14'd1);
    tick(); settle();
    check("addr2", bus.im_addr, 14'd2);

    // 2: streaming, one instruction per cycle after fill
    do_reset(1'b1);
    settle();
    nacc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(); settle();
      if (bus.out_valid) begin
        check("stream_pc", bus.out_pc, nacc * 4);
        check("stream_instr", bus.out_instr, nacc * 4 + 32'h13);
        nacc++;
      end
    end
    nexp = BYP ? 19 : 18;
    check("stream_count", nacc, nexp);

    // 3: stall until full, then release
    do_reset(1'b0);
    settle();
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); settle();
      if (bus.im_req) begin
        check("stall_addr", bus.im_addr, nreq);
        nreq++;
      end
    end
    check("stall_nreq", nreq, DEPTH);
    check("stall_req_off", bus.im_req, 1'b0);
    check("stall_valid", bus.out_valid, 1'b1);
    check("stall_pc", bus.out_pc, 32'h0);
    check("stall_instr", bus.out_instr, 32'h13);
    bus.out_ready = 1'b1;
    nacc = 0;
    for (int i = 0; i < 20 && nacc < 5; i++) begin
      if (bus.out_valid) begin
        check("release_pc", bus.out_pc, nacc * 4);
        nacc++;
      end
      tick(); settle();
    end
    check("release_count", nacc, 5);

    // 4: redirect with queue full and a request in flight
    do_reset(1'b0);
    settle();
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      if (!bus.im_req) break;
    end
    check("t4_full_valid", bus.out_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    settle();
    check("t4_redir_req", bus.im_req, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    settle();
    check("t4_valid_off", bus.out_valid, 1'b0);
    check("t4_req", bus.im_req, 1'b1);
    check("t4_addr", bus.im_addr, 14'h40);
    wait_valid(10);
    check("t4_first_valid", bus.out_valid, 1'b1);
    check("t4_first_pc", bus.out_pc, 32'h100);
    check("t4_first_instr", bus.out_instr, 32'h113);

    // 5: redirect coinciding with a handshake
    do_reset(1'b1);
    settle();
    wait_valid(10);
    repeat (5) begin tick(); settle(); end
    check("t5_valid", bus.out_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    wait_valid(10);
    check("t5_next_pc", bus.out_pc, 32'h200);

    // 6: wrap across 2^32
    repeat (3) begin tick(); settle(); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    check("t6_req", bus.im_req, 1'b1);
    check("t6_addr_hi", bus.im_addr, 14'h3FFF);
    check("t6_valid_t1", bus.out_valid, 1'b0);
    tick(); settle();
    check("t6_addr_wrap", bus.im_addr, 14'h0);
    check("t6_valid_t2", bus.out_valid, BYP);
    if (BYP) check("t6_pc_t2", bus.out_pc, 32'hFFFF_FFFC);
    tick(); settle();
    check("t6_valid_t3", bus.out_valid, 1'b1);
    check("t6_pc_t3", bus.out_pc, BYP ? 32'h0 : 32'hFFFF_FFFC);
    check("t6_instr_t3", bus.out_instr, BYP ? 32'h13 : 32'h0001_000F);

    // random phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      tick();
      rdy_pct = ((i / 200) % 3 == 0) ? 20 : 75;
      bus.out_ready      = ($urandom_range(99) < rdy_pct);
      bus.redirect_valid = ($urandom_range(19) == 0);
      case ($urandom_range(2))
        0: bus.redirect_pc = $urandom;
        1: bus.redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
        default: bus.redirect_pc = $urandom_range(255);
      endcase
      rst = ($urandom_range(99) != 0);
    end
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
